// File: rtl/regs_mp.sv
// regs_mp: multi-port general-purpose register bank.
// Two write lanes from writeback and NUM_RD read lanes toward decode.
// Optional features: a hard-wired zero register, write-to-read bypass,
// and registered reads.
// On a write collision (both lanes, same address) lane 1 wins.
module regs_mp #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 32,
    parameter int NUM_RD     = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1,
    parameter int RD_REG     = 0
) (
    input  logic                           i_CLK,
    input  logic                           i_RST,
    input  logic                           i_we0,
    input  logic [ADDR_WIDTH-1:0]          i_waddr0,
    input  logic [DATA_WIDTH-1:0]          i_wdata0,
    input  logic                           i_we1,
    input  logic [ADDR_WIDTH-1:0]          i_waddr1,
    input  logic [DATA_WIDTH-1:0]          i_wdata1,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]   i_raddr,
    output logic [NUM_RD*DATA_WIDTH-1:0]   o_rdata
);

    // Index width for the storage array.
    // DEPTH <= 2**ADDR_WIDTH, so this is never wider than the address.
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] w_rd  [NUM_RD];

    logic w_acc0;
    logic w_acc1;

    // A write lane is accepted only when all of these hold:
    //   - the lane is enabled and reset is low;
    //   - the address is implemented;
    //   - the address is not the hard-wired zero register.
    // Accepted writes are the only ones that may update state or be bypassed.
    assign w_acc0 = i_we0 && !i_RST && (int'(i_waddr0) < DEPTH)
                    && !((ZERO_REG != 0) && (i_waddr0 == '0));
    assign w_acc1 = i_we1 && !i_RST && (int'(i_waddr1) < DEPTH)
                    && !((ZERO_REG != 0) && (i_waddr1 == '0));

    // Storage update.
    // Lane 1 is assigned last, so it wins when both lanes hit the same address.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_mem <= '{default: '0};
        end else begin
            if (w_acc0) r_mem[i_waddr0[IW-1:0]] <= i_wdata0;
            if (w_acc1) r_mem[i_waddr1[IW-1:0]] <= i_wdata1;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] w_ra;
        logic                  w_ra_ok;
        logic [DATA_WIDTH-1:0] w_val;

        assign w_ra    = i_raddr[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_ra_ok = (int'(w_ra) < DEPTH)
                         && !((ZERO_REG != 0) && (w_ra == '0));

        // Read value for this port.
        // Stored contents first; then, with bypass enabled, the same-cycle
        // accepted write to this address. Lane 1 is checked last so it wins.
        always_comb begin
            w_val = '0;
            if (w_ra_ok) w_val = r_mem[w_ra[IW-1:0]];
            if (BYPASS != 0) begin
                if (w_acc0 && (i_waddr0 == w_ra)) w_val = i_wdata0;
                if (w_acc1 && (i_waddr1 == w_ra)) w_val = i_wdata1;
            end
        end

        if (RD_REG != 0) begin : g_reg
            logic [DATA_WIDTH-1:0] r_q;

            // Registered read.
            // Captures the value presented at this edge; cleared by reset.
            always_ff @(posedge i_CLK) begin
                if (i_RST) r_q <= '0;
                else       r_q <= w_val;
            end

            assign w_rd[k] = r_q;
        end else begin : g_comb
            assign w_rd[k] = w_val;
        end
    end

    // Pack the per-port results onto the flat output bus.
    always_comb begin
        o_rdata = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            o_rdata[k*DATA_WIDTH +: DATA_WIDTH] = w_rd[k];
        end
    end

endmodule

// File: tb/tb_regs_mp.sv
// Testbench for regs_mp.
// Two instances share one set of stimulus:
//   A: zero register, bypass, combinational reads
//   B: no zero register, no bypass, registered reads
// Expected read vectors go into per-instance queues, tagged with the cycle in
// which they should appear. A monitor pops and compares them on the falling edge.
module tb_regs_mp;

    localparam int DW = 8;
    localparam int AW = 5;
    localparam int DEPTH = 20;
    localparam int NR = 4;

    typedef struct {
        int               tag;
        logic [NR*DW-1:0] data;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             we0;
    logic [AW-1:0]    wa0;
    logic [DW-1:0]    wd0;
    logic             we1;
    logic [AW-1:0]    wa1;
    logic [DW-1:0]    wd1;
    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rdata_a;
    logic [NR*DW-1:0] rdata_b;

    logic [DW-1:0] mem_a [DEPTH];
    logic [DW-1:0] mem_b [DEPTH];

    exp_t qa[$];
    exp_t qb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    regs_mp #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .NUM_RD(NR),
        .ZERO_REG(1), .BYPASS(1), .RD_REG(0)
    ) dut_a (
        .i_CLK(clk), .i_RST(rst),
        .i_we0(we0), .i_waddr0(wa0), .i_wdata0(wd0),
        .i_we1(we1), .i_waddr1(wa1), .i_wdata1(wd1),
        .i_raddr(raddr), .o_rdata(rdata_a)
    );

    regs_mp #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .NUM_RD(NR),
        .ZERO_REG(0), .BYPASS(0), .RD_REG(1)
    ) dut_b (
        .i_CLK(clk), .i_RST(rst),
        .i_we0(we0), .i_waddr0(wa0), .i_wdata0(wd0),
        .i_we1(we1), .i_waddr1(wa1), .i_wdata1(wd1),
        .i_raddr(raddr), .o_rdata(rdata_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A write lane is accepted when enabled, out of reset, in range,
    // and not aimed at a hard-wired zero register.
    function automatic bit accepted(input bit zr, input logic we, input logic [AW-1:0] a);
        return we && !rst && (int'(a) < DEPTH) && !(zr && a == 0);
    endfunction

    // Reference read value for one port.
    // Selects instance B's rules when b is set, instance A's rules otherwise.
    function automatic logic [DW-1:0] ref_read(input bit b, input logic [AW-1:0] ra);
        bit            zr  = !b;
        bit            byp = !b;
        logic [DW-1:0] v   = '0;
        if (int'(ra) < DEPTH && !(zr && ra == 0)) v = b ? mem_b[ra] : mem_a[ra];
        if (byp) begin
            if (accepted(zr, we0, wa0) && wa0 == ra) v = wd0;
            if (accepted(zr, we1, wa1) && wa1 == ra) v = wd1;
        end
        return v;
    endfunction

    // Drive one cycle of stimulus, queue expectations, then advance the models.
    task automatic step(input logic r, input logic e0, input logic [AW-1:0] a0,
                        input logic [DW-1:0] d0, input logic e1,
                        input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                        input logic [NR*AW-1:0] ra);
        exp_t ea;
        exp_t eb;
        rst = r; we0 = e0; wa0 = a0; wd0 = d0;
        we1 = e1; wa1 = a1; wd1 = d1; raddr = ra;
        cyc++;
        ea.tag = cyc;
        eb.tag = cyc + 1;
        ea.data = '0;
        eb.data = '0;
        for (int k = 0; k < NR; k++) begin
            ea.data[k*DW +: DW] = ref_read(1'b0, ra[k*AW +: AW]);
            if (!r) eb.data[k*DW +: DW] = ref_read(1'b1, ra[k*AW +: AW]);
        end
        qa.push_back(ea);
        qb.push_back(eb);
        if (r) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_a[i] = '0;
                mem_b[i] = '0;
            end
        end else begin
            if (accepted(1'b1, e0, a0)) mem_a[a0] = d0;
            if (accepted(1'b1, e1, a1)) mem_a[a1] = d1;
            if (accepted(1'b0, e0, a0)) mem_b[a0] = d0;
            if (accepted(1'b0, e1, a1)) mem_b[a1] = d1;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NR*AW-1:0] rd4(input int p0, input int p1, input int p2, input int p3);
        logic [AW-1:0] x0 = AW'(p0);
        logic [AW-1:0] x1 = AW'(p1);
        logic [AW-1:0] x2 = AW'(p2);
        logic [AW-1:0] x3 = AW'(p3);
        return {x3, x2, x1, x0};
    endfunction

    // Monitor: compare every expectation that falls due in the current cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (qa.size() > 0 && qa[0].tag <= cyc) begin
                e = qa.pop_front();
                n_checks++;
                if (e.tag != cyc || rdata_a !== e.data) begin
                    n_errors++;
                    $display("FAIL rdA cyc=%0d tag=%0d got=%h exp=%h", cyc, e.tag, rdata_a, e.data);
                end
            end
            while (qb.size() > 0 && qb[0].tag <= cyc) begin
                e = qb.pop_front();
                n_checks++;
                if (e.tag != cyc || rdata_b !== e.data) begin
                    n_errors++;
                    $display("FAIL rdB cyc=%0d tag=%0d got=%h exp=%h", cyc, e.tag, rdata_b, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic [AW-1:0] rr [NR];
        rst = 1'b1; we0 = 1'b0; wa0 = '0; wd0 = '0;
        we1 = 1'b0; wa1 = '0; wd1 = '0; raddr = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        for (int i = 0; i < DEPTH; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end

        // Basic writes and reads of r1/r2.
        step(0, 1, 1, 8'd55, 0, 0, 0, rd4(1, 2, 0, 0));
        step(0, 1, 2, 8'hAA, 0, 0, 0, rd4(1, 2, 0, 0));
        step(0, 0, 0, 0,     0, 0, 0, rd4(1, 2, 1, 2));
        step(0, 0, 0, 0,     0, 0, 0, rd4(1, 2, 1, 2));

        // Zero register write and read.
        step(0, 1, 0, 8'hFF, 0, 0, 0, rd4(0, 0, 1, 2));
        step(0, 0, 0, 0,     0, 0, 0, rd4(0, 1, 2, 0));
        step(0, 0, 0, 0,     0, 0, 0, rd4(0, 1, 2, 0));

        // Write collision on r3.
        step(0, 1, 3, 8'h11, 1, 3, 8'h22, rd4(3, 3, 0, 1));
        step(0, 0, 0, 0,     0, 0, 0,     rd4(3, 0, 0, 0));
        step(0, 0, 0, 0,     0, 0, 0,     rd4(3, 0, 0, 0));

        // Same-cycle bypass on r4.
        step(0, 1, 4, 8'h5A, 0, 0, 0, rd4(4, 3, 2, 1));
        step(0, 0, 0, 0,     0, 0, 0, rd4(4, 3, 2, 1));
        step(0, 0, 0, 0,     0, 0, 0, rd4(4, 3, 2, 1));

        // Out-of-range write and read.
        step(0, 0, 0, 0, 1, 25, 8'h77, rd4(25, 5, 19, 20));
        step(0, 0, 0, 0, 0, 0,  0,     rd4(25, 5, 19, 31));

        // Preload r5..r8 and read them on all four ports.
        step(0, 1, 5, 8'd1, 1, 6, 8'd2, rd4(0, 0, 0, 0));
        step(0, 1, 7, 8'd3, 1, 8, 8'd4, rd4(5, 6, 7, 8));
        step(0, 0, 0, 0,    0, 0, 0,    rd4(5, 6, 7, 8));
        step(0, 0, 0, 0,    0, 0, 0,    rd4(5, 6, 7, 8));

        // Reset in mid-operation; the write to r2 must be discarded.
        step(0, 1, 1, 8'd55, 0, 0, 0,    rd4(1, 2, 0, 0));
        step(1, 1, 2, 8'h99, 1, 1, 8'h3C, rd4(1, 2, 5, 6));
        step(0, 0, 0, 0,     0, 0, 0,    rd4(1, 2, 5, 6));
        step(0, 0, 0, 0,     0, 0, 0,    rd4(1, 2, 5, 6));

        // Randomized traffic with occasional reset.
        for (int n = 0; n < 400; n++) begin
            a0 = ($urandom_range(0, 2) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
            a1 = ($urandom_range(0, 2) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) a1 = a0;
            for (int k = 0; k < NR; k++) begin
                case ($urandom_range(0, 3))
                    0:       rr[k] = a0;
                    1:       rr[k] = a1;
                    2:       rr[k] = AW'($urandom_range(0, 31));
                    default: rr[k] = AW'($urandom_range(0, 7));
                endcase
            end
            step(($urandom_range(0, 49) == 0),
                 1'($urandom_range(0, 1)), a0, DW'($urandom),
                 1'($urandom_range(0, 1)), a1, DW'($urandom),
                 {rr[3], rr[2], rr[1], rr[0]});
        end

        // One more cycle so the last registered read falls due.
        we0 = 1'b0;
        we1 = 1'b0;
        cyc++;
        @(negedge clk);
        #1;
        n_checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            n_errors++;
            $display("FAIL drain pending_a=%0d pending_b=%0d exp=0", qa.size(), qb.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regs_mp.md
# regs_mp

Parametrised multi-port register file: the next-generation general-purpose register bank for the datapath, with NUM_RD read ports, two write ports, optional hard-wired zero register, optional write-to-read bypass, and selectable combinational or registered reads. It sits between instruction decode (read addresses) and writeback (two retire lanes).

## Interface
- DATA_WIDTH, 8, width of each register
- ADDR_WIDTH, 5, register address width
- DEPTH, 32, number of implemented registers, 1..2**ADDR_WIDTH
- NUM_RD, 2, number of read ports, 1..8
- ZERO_REG, 1, 1: register 0 reads 0 and ignores writes
- BYPASS, 1, 1: a same-cycle write is visible on a read of the same address
- RD_REG, 0, 0: combinational reads; 1: reads registered, latency 1
- i_CLK  in  1  clock, all state updates on rising edge
- i_RST  in  1  synchronous, active-high reset
- i_we0  in  1  write enable, port 0
- i_waddr0  in  ADDR_WIDTH  write address, port 0
- i_wdata0  in  DATA_WIDTH  write data, port 0
- i_we1  in  1  write enable, port 1
- i_waddr1  in  ADDR_WIDTH  write address, port 1
- i_wdata1  in  DATA_WIDTH  write data, port 1
- i_raddr  in  NUM_RD*ADDR_WIDTH  read addresses, port k at bits [k*ADDR_WIDTH +: ADDR_WIDTH]
- o_rdata  out  NUM_RD*DATA_WIDTH  read data, port k at bits [k*DATA_WIDTH +: DATA_WIDTH]

## Operation
- Write: on a rising edge with i_RST=0, each enabled port writes its data to its address.
- Collision: both ports enabled, same address -> port 1 wins. Port 0 is dropped.
- Ignored writes: address >= DEPTH; address 0 when ZERO_REG=1. Neither changes any state.
- Read: any address, any port, independently. Several ports may read the same address.
- Read value:
  - address >= DEPTH -> 0
  - address 0 with ZERO_REG=1 -> 0
  - otherwise -> stored contents
- Bypass (BYPASS=1): if an accepted write targets the read address in the same cycle, the read returns that write data (port 1 data on collision). Ignored writes are never bypassed.
- BYPASS=0: a read returns the pre-edge contents.
- Reset: all DEPTH registers are cleared to 0. Writes presented while i_RST=1 are discarded, including mid-sequence. Bypass is suppressed while i_RST=1.

## Timing
- RD_REG=0:
  - o_rdata is combinational from i_raddr, the stored contents and (when BYPASS=1) the write ports.
  - A write becomes visible on the read path one edge after it is presented; with BYPASS=1 it is visible in the same cycle.
- RD_REG=1:
  - o_rdata is registered. The value sampled at edge N reflects the addresses at edge N.
  - With BYPASS=1, the sample includes writes accepted at edge N. With BYPASS=0, it holds the pre-edge contents.
  - The output is valid after edge N, so latency is 1 cycle.
- Reset values: all stored registers 0. With RD_REG=1, o_rdata is 0 the cycle after reset is sampled. With RD_REG=0, o_rdata follows the cleared contents, so it is all-zero for in-range addresses.
- Both write ports and all read ports are serviced every cycle. There are no stalls and no handshake.

## Test plan
- Reset, then write 8'd55 to r1 and 8'hAA to r2 in consecutive cycles; read r1 and r2 on ports 0 and 1 -> 55 and AA. RD_REG=0 gives the result the next cycle; RD_REG=1 adds one more cycle.
- Write 8'hFF to r0 with ZERO_REG=1 -> reads of r0 return 0. Repeat with ZERO_REG=0 -> reads return FF.
- Collision: i_we0/i_we1 both to r3 with data 8'h11 and 8'h22 -> r3 reads 22 afterwards. With BYPASS=1, a read of r3 in the same cycle returns 22.
- Bypass: write 8'h5A to r4 while port 0 reads r4 (previously 0) -> BYPASS=1 returns 5A in the same cycle; BYPASS=0 returns 0, then 5A on the next cycle.
- Range: with DEPTH=20, write 8'h77 to address 25 -> a read of 25 returns 0 and no implemented register changes. NUM_RD=4, with all ports reading distinct registers r5..r8 preloaded with 1..4 -> ports return 1,2,3,4 in order.
- Reset mid-operation: load r1=55. Assert i_RST for one cycle while i_we0 writes 8'h99 to r2 -> after reset, r1 and r2 both read 0, and o_rdata is 0 in the first post-reset cycle for RD_REG=1.
